// File: rtl/sys_defs.sv
// ----------------------------------------------------------------------------
// sys_defs: shared types for the load issue unit and its store-queue peer.
//   LOAD_SQ_PACKET : load -> sq lookup {addr, tail_idx}
//   SQ_LOAD_PACKET : sq -> load forward {stall, usebytes, data}
//   LD_SLOT_STATE  : per-slot load state
//   LD_SIZE        : load access size encoding
//   sat_add        : saturating 32-bit add used by the optional perf counters
// ----------------------------------------------------------------------------
package sys_defs;

    localparam int N_LD_SLOTS  = 2;
    localparam int TAG_BITS    = 6;
    localparam int SQ_IDX_BITS = 3;
    localparam int SLOT_BITS   = (N_LD_SLOTS > 1) ? $clog2(N_LD_SLOTS) : 1;

    typedef struct packed {
        logic [31:0]            addr;
        logic [SQ_IDX_BITS-1:0] tail_idx;
    } LOAD_SQ_PACKET;

    typedef struct packed {
        logic        stall;
        logic [3:0]  usebytes;
        logic [31:0] data;
    } SQ_LOAD_PACKET;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_LOOKUP,
        LD_CREQ,
        LD_CWAIT,
        LD_DONE
    } LD_SLOT_STATE;

    typedef enum logic [1:0] {
        LD_BYTE = 2'd0,
        LD_HALF = 2'd1,
        LD_WORD = 2'd2
    } LD_SIZE;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hffff_ffff : s[31:0];
    endfunction

endpackage

// File: rtl/load_data_align.sv
// ----------------------------------------------------------------------------
// load_data_align: combinational byte-need mask and result extraction for one
// load slot.
//   offset : addr[1:0] of the load (masked to size alignment internally)
//   size   : LD_SIZE encoding (byte/half/word; anything else acts as word)
//   sgn    : sign-extend the extracted value
//   merged : 32-bit word holding the load's bytes in memory lane order
//   need   : byte lanes the load consumes
//   value  : aligned, truncated and extended result
// ----------------------------------------------------------------------------
module load_data_align
    import sys_defs::*;
(
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [31:0] merged,
    output logic [3:0]  need,
    output logic [31:0] value
);

    logic [1:0]  off_al;
    logic [31:0] shifted;

    always_comb begin
        off_al  = 2'b00;
        need    = 4'b1111;
        shifted = merged;
        value   = merged;
        case (size)
            LD_BYTE: begin
                off_al = offset;
                need   = 4'b0001 << offset;
            end
            LD_HALF: begin
                off_al = {offset[1], 1'b0};
                need   = 4'b0011 << off_al;
            end
            default: ;
        endcase
        shifted = merged >> {off_al, 3'b000};
        case (size)
            LD_BYTE: value = {{24{sgn & shifted[7]}}, shifted[7:0]};
            LD_HALF: value = {{16{sgn & shifted[15]}}, shifted[15:0]};
            default: value = shifted;
        endcase
    end

endmodule

// File: rtl/load_issue_unit.sv
// ----------------------------------------------------------------------------
// load_issue_unit: load-side initiator of store-queue forwarding. Each of
// N_LD_SLOTS slots looks up sq, retries on stall, falls back to a shared
// single-port dcache read for partially forwarded loads, and holds the
// extended result for CDB writeback.
//   clock/reset      : clock, synchronous active-low reset
//   issue_*          : per-slot load issue from RS (issue_ready = slot idle)
//   load_lookup      : per-slot {addr & ~3, tail_idx} to sq
//   load_forward     : per-slot {stall, usebytes, data} from sq
//   dc_req_*/dc_resp_*: dcache read port (one outstanding request)
//   wb_*             : per-slot writeback, held until wb_ack
//   squash           : flush all slots
// Optional: define LOAD_PERF_CNT_EN to add perf_fwd_full, perf_cache_reads
// and perf_stall_cycles (saturating 32-bit counters).
//
// state     | meaning
// LD_IDLE   | slot free, accepts an issue
// LD_LOOKUP | querying sq, repeats while stall
// LD_CREQ   | partial forward, requesting the dcache port
// LD_CWAIT  | dcache request accepted, waiting for read data
// LD_DONE   | result held on wb_* until wb_ack
// ----------------------------------------------------------------------------
module load_issue_unit
    import sys_defs::*;
(
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic [N_LD_SLOTS-1:0]                   issue_valid,
    output logic [N_LD_SLOTS-1:0]                   issue_ready,
    input  logic [N_LD_SLOTS-1:0][31:0]             issue_addr,
    input  logic [N_LD_SLOTS-1:0][1:0]              issue_size,
    input  logic [N_LD_SLOTS-1:0]                   issue_signed,
    input  logic [N_LD_SLOTS-1:0][SQ_IDX_BITS-1:0]  issue_tail_idx,
    input  logic [N_LD_SLOTS-1:0][TAG_BITS-1:0]     issue_tag,
    output LOAD_SQ_PACKET [N_LD_SLOTS-1:0]          load_lookup,
    input  SQ_LOAD_PACKET [N_LD_SLOTS-1:0]          load_forward,
    output logic                                    dc_req_valid,
    output logic [31:0]                             dc_req_addr,
    input  logic                                    dc_req_ready,
    input  logic                                    dc_resp_valid,
    input  logic [31:0]                             dc_resp_data,
    output logic [N_LD_SLOTS-1:0]                   wb_valid,
    output logic [N_LD_SLOTS-1:0][TAG_BITS-1:0]     wb_tag,
    output logic [N_LD_SLOTS-1:0][31:0]             wb_value,
    input  logic [N_LD_SLOTS-1:0]                   wb_ack,
    input  logic                                    squash
`ifdef LOAD_PERF_CNT_EN
    ,
    output logic [31:0]                             perf_fwd_full,
    output logic [31:0]                             perf_cache_reads,
    output logic [31:0]                             perf_stall_cycles
`endif
);

    LD_SLOT_STATE           state     [N_LD_SLOTS];
    LD_SLOT_STATE           state_nxt [N_LD_SLOTS];
    logic [31:0]            addr_q    [N_LD_SLOTS];
    logic [1:0]             size_q    [N_LD_SLOTS];
    logic                   sgn_q     [N_LD_SLOTS];
    logic [SQ_IDX_BITS-1:0] tail_q    [N_LD_SLOTS];
    logic [TAG_BITS-1:0]    tag_q     [N_LD_SLOTS];
    logic [3:0]             fwd_mask_q[N_LD_SLOTS];
    logic [31:0]            fwd_data_q[N_LD_SLOTS];
    logic [31:0]            value_q   [N_LD_SLOTS];
    logic [3:0]             need      [N_LD_SLOTS];
    logic [31:0]            merged    [N_LD_SLOTS];
    logic [31:0]            aligned   [N_LD_SLOTS];

    logic                   pending, drain, req_locked, any_creq, dc_accept;
    logic [SLOT_BITS-1:0]   owner, req_slot, sel;

    for (genvar g = 0; g < N_LD_SLOTS; g++) begin : g_align
        load_data_align u_align (
            .offset (addr_q[g][1:0]),
            .size   (size_q[g]),
            .sgn    (sgn_q[g]),
            .merged (merged[g]),
            .need   (need[g]),
            .value  (aligned[g])
        );
    end

    // Lowest CREQ slot wins, but once a request is shown and not yet
    // accepted it stays locked so the address cannot change under the cache.
    always_comb begin
        any_creq = 1'b0;
        sel      = '0;
        for (int i = N_LD_SLOTS - 1; i >= 0; i--) begin
            if (state[i] == LD_CREQ) begin
                any_creq = 1'b1;
                sel      = SLOT_BITS'(i);
            end
        end
        if (req_locked) begin
            any_creq = 1'b1;
            sel      = req_slot;
        end
        dc_req_valid = any_creq && !pending && !drain;
        dc_req_addr  = {addr_q[sel][31:2], 2'b00};
        dc_accept    = dc_req_valid && dc_req_ready;
    end

    always_comb begin
        for (int i = 0; i < N_LD_SLOTS; i++) begin
            state_nxt[i] = state[i];
            for (int k = 0; k < 4; k++) begin
                if (state[i] == LD_CWAIT)
                    merged[i][8*k +: 8] = fwd_mask_q[i][k] ? fwd_data_q[i][8*k +: 8]
                                                           : dc_resp_data[8*k +: 8];
                else
                    merged[i][8*k +: 8] = load_forward[i].data[8*k +: 8];
            end
            case (state[i])
                LD_IDLE:   if (issue_valid[i]) state_nxt[i] = LD_LOOKUP;
                LD_LOOKUP: if (!load_forward[i].stall)
                               state_nxt[i] = ((load_forward[i].usebytes & need[i]) == need[i])
                                              ? LD_DONE : LD_CREQ;
                LD_CREQ:   if (dc_accept && sel == SLOT_BITS'(i)) state_nxt[i] = LD_CWAIT;
                LD_CWAIT:  if (dc_resp_valid && pending && owner == SLOT_BITS'(i))
                               state_nxt[i] = LD_DONE;
                LD_DONE:   if (wb_ack[i]) state_nxt[i] = LD_IDLE;
                default:   state_nxt[i] = LD_IDLE;
            endcase
            if (squash) state_nxt[i] = LD_IDLE;
            issue_ready[i]          = (state[i] == LD_IDLE);
            wb_valid[i]             = (state[i] == LD_DONE);
            wb_tag[i]               = tag_q[i];
            wb_value[i]             = value_q[i];
            load_lookup[i].addr     = (state[i] == LD_LOOKUP) ? {addr_q[i][31:2], 2'b00} : 32'd0;
            load_lookup[i].tail_idx = (state[i] == LD_LOOKUP) ? tail_q[i] : '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < N_LD_SLOTS; i++) begin
                state[i]      <= LD_IDLE;
                addr_q[i]     <= '0;
                size_q[i]     <= '0;
                sgn_q[i]      <= 1'b0;
                tail_q[i]     <= '0;
                tag_q[i]      <= '0;
                fwd_mask_q[i] <= '0;
                fwd_data_q[i] <= '0;
                value_q[i]    <= '0;
            end
            pending    <= 1'b0;
            drain      <= 1'b0;
            req_locked <= 1'b0;
            owner      <= '0;
            req_slot   <= '0;
        end else begin
            for (int i = 0; i < N_LD_SLOTS; i++) begin
                state[i] <= state_nxt[i];
                if (state[i] == LD_IDLE && issue_valid[i] && !squash) begin
                    addr_q[i] <= issue_addr[i];
                    size_q[i] <= issue_size[i];
                    sgn_q[i]  <= issue_signed[i];
                    tail_q[i] <= issue_tail_idx[i];
                    tag_q[i]  <= issue_tag[i];
                end
                if (state[i] == LD_LOOKUP && !load_forward[i].stall) begin
                    fwd_mask_q[i] <= load_forward[i].usebytes & need[i];
                    fwd_data_q[i] <= load_forward[i].data;
                    value_q[i]    <= aligned[i];
                end
                if (state[i] == LD_CWAIT)
                    value_q[i] <= aligned[i];
            end
            if (squash) begin
                // A response still owed by the cache must be swallowed, unless
                // it is arriving right now; a same-cycle accept also owes one.
                drain      <= dc_accept || ((drain || pending) && !dc_resp_valid);
                pending    <= 1'b0;
                req_locked <= 1'b0;
            end else begin
                if (dc_accept) begin
                    pending <= 1'b1;
                    owner   <= sel;
                end else if (dc_resp_valid) begin
                    if (drain) drain <= 1'b0;
                    else       pending <= 1'b0;
                end
                req_locked <= dc_req_valid && !dc_req_ready;
                if (dc_req_valid && !dc_req_ready) req_slot <= sel;
            end
        end
    end

`ifdef LOAD_PERF_CNT_EN
    logic [31:0] n_full, n_stall;

    always_comb begin
        n_full  = '0;
        n_stall = '0;
        for (int i = 0; i < N_LD_SLOTS; i++) begin
            if (state[i] == LD_LOOKUP && state_nxt[i] == LD_DONE) n_full  = n_full + 32'd1;
            if (state[i] == LD_LOOKUP && load_forward[i].stall)   n_stall = n_stall + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            perf_fwd_full     <= '0;
            perf_cache_reads  <= '0;
            perf_stall_cycles <= '0;
        end else begin
            perf_fwd_full     <= sat_add(perf_fwd_full, n_full);
            perf_cache_reads  <= sat_add(perf_cache_reads, {31'd0, dc_accept});
            perf_stall_cycles <= sat_add(perf_stall_cycles, n_stall);
        end
    end
`endif

endmodule

// File: tb/tb_load_issue_unit.sv
module tb_load_issue_unit;
    import sys_defs::*;

    logic                                    clock = 1'b0;
    logic                                    reset;
    logic [N_LD_SLOTS-1:0]                   issue_valid;
    logic [N_LD_SLOTS-1:0]                   issue_ready;
    logic [N_LD_SLOTS-1:0][31:0]             issue_addr;
    logic [N_LD_SLOTS-1:0][1:0]              issue_size;
    logic [N_LD_SLOTS-1:0]                   issue_signed;
    logic [N_LD_SLOTS-1:0][SQ_IDX_BITS-1:0]  issue_tail_idx;
    logic [N_LD_SLOTS-1:0][TAG_BITS-1:0]     issue_tag;
    LOAD_SQ_PACKET [N_LD_SLOTS-1:0]          load_lookup;
    SQ_LOAD_PACKET [N_LD_SLOTS-1:0]          load_forward;
    logic                                    dc_req_valid;
    logic [31:0]                             dc_req_addr;
    logic                                    dc_req_ready;
    logic                                    dc_resp_valid;
    logic [31:0]                             dc_resp_data;
    logic [N_LD_SLOTS-1:0]                   wb_valid;
    logic [N_LD_SLOTS-1:0][TAG_BITS-1:0]     wb_tag;
    logic [N_LD_SLOTS-1:0][31:0]             wb_value;
    logic [N_LD_SLOTS-1:0]                   wb_ack;
    logic                                    squash;

    int n_checks = 0;
    int n_pass   = 0;

    load_issue_unit dut (
        .clock          (clock),
        .reset          (reset),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .issue_addr     (issue_addr),
        .issue_size     (issue_size),
        .issue_signed   (issue_signed),
        .issue_tail_idx (issue_tail_idx),
        .issue_tag      (issue_tag),
        .load_lookup    (load_lookup),
        .load_forward   (load_forward),
        .dc_req_valid   (dc_req_valid),
        .dc_req_addr    (dc_req_addr),
        .dc_req_ready   (dc_req_ready),
        .dc_resp_valid  (dc_resp_valid),
        .dc_resp_data   (dc_resp_data),
        .wb_valid       (wb_valid),
        .wb_tag         (wb_tag),
        .wb_value       (wb_value),
        .wb_ack         (wb_ack),
        .squash         (squash)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic issue(input int s, input logic [31:0] a, input logic [1:0] sz,
                         input logic sg, input logic [SQ_IDX_BITS-1:0] ti,
                         input logic [TAG_BITS-1:0] tg);
        issue_valid[s]    = 1'b1;
        issue_addr[s]     = a;
        issue_size[s]     = sz;
        issue_signed[s]   = sg;
        issue_tail_idx[s] = ti;
        issue_tag[s]      = tg;
    endtask

    task automatic fwd(input int s, input logic st, input logic [3:0] ub, input logic [31:0] d);
        load_forward[s].stall    = st;
        load_forward[s].usebytes = ub;
        load_forward[s].data     = d;
    endtask

    initial begin
        reset          = 1'b0;
        issue_valid    = '0;
        issue_addr     = '0;
        issue_size     = '0;
        issue_signed   = '0;
        issue_tail_idx = '0;
        issue_tag      = '0;
        load_forward   = '0;
        dc_req_ready   = 1'b0;
        dc_resp_valid  = 1'b0;
        dc_resp_data   = '0;
        wb_ack         = '0;
        squash         = 1'b0;

        // reset state
        tick();
        tick();
        check("rst_issue_ready", issue_ready, 2'b11);
        check("rst_wb_valid", wb_valid, 2'b00);
        check("rst_dc_req_valid", dc_req_valid, 0);
        check("rst_lookup0", {load_lookup[0].addr, load_lookup[0].tail_idx}, 0);
        reset = 1'b1;
        tick();

        // full forward, word
        issue(0, 32'h0000_00c0, 2'd2, 1'b0, 3'd4, 6'd5);
        tick();
        issue_valid = '0;
        fwd(0, 1'b0, 4'b1111, 32'h87ff_ff21);
        check("ff_lookup_addr", load_lookup[0].addr, 32'hc0);
        check("ff_lookup_tail", load_lookup[0].tail_idx, 3'd4);
        check("ff_issue_ready", issue_ready, 2'b10);
        tick();
        check("ff_wb_valid", wb_valid, 2'b01);
        check("ff_wb_value", wb_value[0], 32'h87ff_ff21);
        check("ff_wb_tag", wb_tag[0], 6'd5);
        check("ff_no_dcreq", dc_req_valid, 0);
        wb_ack = 2'b01;
        tick();
        wb_ack = '0;
        check("ff_ack_wb_valid", wb_valid, 2'b00);
        check("ff_ack_ready", issue_ready, 2'b11);

        // stall then forward, signed byte on slot 1
        issue(1, 32'h0000_00c1, 2'd0, 1'b1, 3'd2, 6'd9);
        tick();
        issue_valid = '0;
        fwd(1, 1'b1, 4'b0000, 32'h0);
        for (int k = 0; k < 3; k++) begin
            check("st_lookup_addr", load_lookup[1].addr, 32'hc0);
            check("st_wb_valid", wb_valid, 2'b00);
            tick();
        end
        fwd(1, 1'b0, 4'b0010, 32'h0000_ff00);
        check("st_lookup_addr_last", load_lookup[1].addr, 32'hc0);
        check("st_lookup_tail", load_lookup[1].tail_idx, 3'd2);
        tick();
        check("st_wb_valid_done", wb_valid, 2'b10);
        check("st_wb_value", wb_value[1], 32'hffff_ffff);
        check("st_wb_tag", wb_tag[1], 6'd9);
        wb_ack = 2'b10;
        tick();
        wb_ack = '0;

        // partial forward merged with cache, request held until ready
        issue(0, 32'h0000_00f0, 2'd2, 1'b0, 3'd1, 6'd3);
        tick();
        issue_valid = '0;
        fwd(0, 1'b0, 4'b0011, 32'h0000_2345);
        tick();
        fwd(0, 1'b0, 4'b1111, 32'hdead_beef);
        check("pc_req_valid", dc_req_valid, 1);
        check("pc_req_addr", dc_req_addr, 32'hf0);
        tick();
        check("pc_req_held", dc_req_valid, 1);
        check("pc_req_addr_held", dc_req_addr, 32'hf0);
        dc_req_ready = 1'b1;
        tick();
        dc_req_ready = 1'b0;
        check("pc_req_dropped", dc_req_valid, 0);
        check("pc_wait_wb", wb_valid, 2'b00);
        dc_resp_valid = 1'b1;
        dc_resp_data  = 32'haabb_ccdd;
        tick();
        dc_resp_valid = 1'b0;
        check("pc_wb_valid", wb_valid, 2'b01);
        check("pc_wb_value", wb_value[0], 32'haabb_2345);
        wb_ack = 2'b01;
        tick();
        wb_ack = '0;

        // contention: both miss together, slot0 first
        issue(0, 32'h0000_0100, 2'd2, 1'b0, 3'd0, 6'd10);
        issue(1, 32'h0000_0202, 2'd1, 1'b0, 3'd0, 6'd11);
        tick();
        issue_valid = '0;
        fwd(0, 1'b0, 4'b0000, 32'h0);
        fwd(1, 1'b0, 4'b0000, 32'h0);
        dc_req_ready = 1'b1;
        tick();
        check("ct_req0_valid", dc_req_valid, 1);
        check("ct_req0_addr", dc_req_addr, 32'h100);
        tick();
        check("ct_one_outstanding", dc_req_valid, 0);
        dc_resp_valid = 1'b1;
        dc_resp_data  = 32'h1111_1111;
        tick();
        dc_resp_valid = 1'b0;
        check("ct_wb0_valid", wb_valid, 2'b01);
        check("ct_wb0_value", wb_value[0], 32'h1111_1111);
        check("ct_req1_valid", dc_req_valid, 1);
        check("ct_req1_addr", dc_req_addr, 32'h200);
        tick();
        check("ct_req1_taken", dc_req_valid, 0);
        dc_resp_valid = 1'b1;
        dc_resp_data  = 32'h2222_2222;
        wb_ack        = 2'b01;
        tick();
        dc_resp_valid = 1'b0;
        wb_ack        = '0;
        check("ct_wb1_valid", wb_valid, 2'b10);
        check("ct_wb1_value", wb_value[1], 32'h0000_2222);
        check("ct_wb1_tag", wb_tag[1], 6'd11);
        wb_ack = 2'b10;
        tick();
        wb_ack = '0;
        dc_req_ready = 1'b0;

        // squash with a pending request, and an issue in the squash cycle
        issue(0, 32'h0000_0300, 2'd2, 1'b0, 3'd0, 6'd12);
        tick();
        issue_valid = '0;
        fwd(0, 1'b0, 4'b0000, 32'h0);
        dc_req_ready = 1'b1;
        tick();
        tick();
        dc_req_ready = 1'b0;
        squash = 1'b1;
        issue(1, 32'h0000_0700, 2'd2, 1'b0, 3'd0, 6'd20);
        tick();
        squash      = 1'b0;
        issue_valid = '0;
        check("sq_wb_valid", wb_valid, 2'b00);
        check("sq_issue_ready", issue_ready, 2'b11);
        check("sq_dc_req", dc_req_valid, 0);
        issue(1, 32'h0000_0400, 2'd2, 1'b0, 3'd0, 6'd13);
        tick();
        issue_valid = '0;
        fwd(1, 1'b0, 4'b0001, 32'h0000_00ee);
        dc_req_ready = 1'b1;
        tick();
        check("sq_drain_block1", dc_req_valid, 0);
        tick();
        check("sq_drain_block2", dc_req_valid, 0);
        dc_resp_valid = 1'b1;
        dc_resp_data  = 32'h5555_5555;
        tick();
        dc_resp_valid = 1'b0;
        check("sq_stale_dropped", wb_valid, 2'b00);
        check("sq_new_req", dc_req_valid, 1);
        check("sq_new_addr", dc_req_addr, 32'h400);
        tick();
        dc_req_ready  = 1'b0;
        dc_resp_valid = 1'b1;
        dc_resp_data  = 32'h6666_6666;
        tick();
        dc_resp_valid = 1'b0;
        check("sq_new_wb_valid", wb_valid, 2'b10);
        check("sq_new_value", wb_value[1], 32'h6666_66ee);
        check("sq_new_tag", wb_tag[1], 6'd13);
        wb_ack = 2'b10;
        tick();
        wb_ack = '0;

        // reset with slot0 in DONE and slot1 stalled in LOOKUP
        issue(0, 32'h0000_0500, 2'd2, 1'b0, 3'd0, 6'd1);
        tick();
        issue(1, 32'h0000_0504, 2'd2, 1'b0, 3'd0, 6'd2);
        issue_valid[0] = 1'b0;
        fwd(0, 1'b0, 4'b1111, 32'h1234_5678);
        fwd(1, 1'b1, 4'b0000, 32'h0);
        tick();
        issue_valid = '0;
        check("rm_pre_wb_valid", wb_valid, 2'b01);
        check("rm_pre_ready", issue_ready, 2'b00);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("rm_wb_valid", wb_valid, 2'b00);
        check("rm_issue_ready", issue_ready, 2'b11);
        check("rm_dc_req", dc_req_valid, 0);
        issue(0, 32'h0000_0600, 2'd2, 1'b0, 3'd0, 6'd4);
        tick();
        issue_valid = '0;
        fwd(0, 1'b0, 4'b0000, 32'h0);
        tick();
        check("rm_post_req", dc_req_valid, 1);
        check("rm_post_addr", dc_req_addr, 32'h600);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
